regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-back side controller for the 16x16 register file (2 read ports, 1 write port, r0 reads as zero).
- Merges two result producers into the single regfile write port:
  - the single-cycle ALU path;
  - the long-latency path (load/multiply unit), held in a small ordered pending buffer.
- Exports a busy scoreboard so the hazard unit can stall readers of registers whose value is still queued.

Parameters:
- DEPTH, 4, pending-buffer entries (power of two, >=2)
- AW, 4, register address width
- DW, 16, data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_vld  in  1  ALU result valid this cycle; always accepted
- alu_adr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- lu_vld  in  1  long-latency result offered
- lu_rdy  out  1  buffer can accept; transfer when lu_vld && lu_rdy
- lu_adr  in  AW  long-latency destination register
- lu_data  in  DW  long-latency result
- wr_en  out  1  to regfile writeEn
- wr_adr  out  AW  to regfile writeAdr
- wr_data  out  DW  to regfile writeData
- busy  out  2**AW  bit i set while a live buffered entry targets register i
- fwd_adr1, fwd_adr2  in  AW  bypass lookup addresses (only with WB_BYPASS_EN)
- fwd_hit1, fwd_hit2  out  1  bypass hit (only with WB_BYPASS_EN)
- fwd_data1, fwd_data2  out  DW  bypass data (only with WB_BYPASS_EN)

Behaviour:
- Reset: clk-synchronous, rst high.
  - wr_en=0, wr_adr=0, wr_data=0.
  - Buffer emptied, all stale flags cleared, busy=0, lu_rdy=1 from the next cycle.
  - Reset mid-operation discards all queued entries with no write issued.
- Write port outputs are registered: one-cycle latency from selection to wr_en/wr_adr/wr_data.
- Selection each cycle, in priority order:
  - (a) ALU: if alu_vld && alu_adr!=0, issue the ALU write.
  - (b) Buffer head: otherwise, if the head is live, pop it and issue its write.
  - Otherwise wr_en=0.
- Stale entries:
  - A stale head pops every cycle, even when the ALU owns the port, and issues no write.
- Address 0:
  - ALU writes to r0 are ignored; no port use, and they do not block the buffer.
  - lu transfers to r0 complete the handshake but store nothing.
- Buffer: in-order FIFO of {adr, data, stale}.
  - Pointers wrap modulo DEPTH; count range 0..DEPTH.
  - lu_rdy = (count != DEPTH), registered. No push when full, even if a pop occurs that cycle.
  - Push and pop in the same cycle leave count unchanged.
- Ordering rule: a committed ALU write to register A sets stale on every buffered entry with adr==A, because that result is younger than those entries.
  - An entry pushed in the same cycle as the ALU commit is not marked stale; the lu result is younger.
- busy[i] = OR over valid, non-stale entries with adr==i. busy[0]=0 always. busy is combinational from buffer state.
- Simultaneous alu_vld and live head: the head waits. There is no starvation bound; the pipeline guarantees ALU bubbles.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - The fwd_* ports exist.
  - fwd_hitN=1 and fwd_dataN = youngest matching source for fwd_adrN:
    - first, the registered write stage when wr_en && wr_adr==fwd_adrN;
    - otherwise, the youngest live buffer entry.
  - Lookup is combinational. fwd_adrN==0 never hits.
- Undefined: the ports are absent and readers rely on busy stalls only.

Decomposition:
- Shared package:
  - AW/DW defaults;
  - register-count constant;
  - pending-entry struct {adr, data, stale};
  - R0 address constant.
- One natural sub-module: wb_pend_fifo.
  - Storage, pointers and count.
  - Stale-marking compare against an address.
  - Per-entry valid/stale vectors exported for busy and bypass.

Test Plan:
- Reset: rst high for 2 cycles mid-traffic -> wr_en=0, busy=0, lu_rdy=1, and no write of the queued data afterward.
- ALU only: alu r3=0x1234 at cycle N -> wr_en=1, wr_adr=3, wr_data=0x1234 at N+1. Then alu r0=0xFFFF -> wr_en=0.
- lu contention: push lu r5=0xAAAA while ALU writes r2, r4 on consecutive cycles -> busy[5]=1; r5 written on the first alu-idle cycle; busy[5] clears.
- Stale: push lu r7=0x1111, then alu r7=0x2222 before drain -> only 0x2222 written to r7; stale entry drains silently; busy[7]=0.
- Full: lu_vld held high for 6 cycles with ALU busy -> exactly DEPTH accepted, lu_rdy=0. After ALU idles, entries written in push order and lu_rdy returns.
- Bypass (WB_BYPASS_EN): two buffered r6 entries 0x10 then 0x20, fwd_adr1=6 -> fwd_hit1=1, fwd_data1=0x20. fwd_adr2=0 -> fwd_hit2=0.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
// Default widths match the 16x16 register file; r0 is hardwired to zero.
package regfile_wb_ctrl_pkg;

   localparam int WB_AW    = 4;
   localparam int WB_DW    = 16;
   localparam int NUM_REGS = 2 ** WB_AW;

   localparam logic [WB_AW-1:0] R0_ADR = '0;

   typedef struct packed {
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] data;
      logic             stale;
   } pend_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Ordered pending buffer for long-latency results, with per-entry stale marking
// and per-slot valid/stale/address/data views for the scoreboard and bypass logic.
module wb_pend_fifo
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WB_AW-1:0]               push_adr,
   input  logic [WB_DW-1:0]               push_data,
   input  logic                           pop,
   input  logic                           mark_en,
   input  logic [WB_AW-1:0]               mark_adr,
   output logic                           rdy,
   output logic [$clog2(DEPTH)-1:0]       head_ptr,
   output logic [DEPTH-1:0]               slot_vld,
   output logic [DEPTH-1:0]               slot_stale,
   output logic [DEPTH-1:0][WB_AW-1:0]    slot_adr,
   output logic [DEPTH-1:0][WB_DW-1:0]    slot_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   pend_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [DEPTH-1:0]        vld_q, vld_d;
   logic [PW-1:0]           head_q, head_d;
   logic [PW-1:0]           tail_q, tail_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    rdy_q, rdy_d;
   logic                    push_ok;
   logic                    pop_ok;

   // Marking sees only entries already stored, so a same-cycle push stays live.
   always_comb begin
      mem_d   = mem_q;
      vld_d   = vld_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      push_ok = push && rdy_q;
      pop_ok  = pop && vld_q[head_q];

      for (int i = 0; i < DEPTH; i++) begin
         if (mark_en && vld_q[i] && (mem_q[i].adr == mark_adr)) begin
            mem_d[i].stale = 1'b1;
         end
      end

      if (pop_ok) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PW'(1);
      end

      if (push_ok) begin
         mem_d[tail_q] = '{adr: push_adr, data: push_data, stale: 1'b0};
         vld_d[tail_q] = 1'b1;
         tail_d        = tail_q + PW'(1);
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      rdy_d = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '0;
         vld_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rdy_q   <= 1'b1;
      end else begin
         mem_q   <= mem_d;
         vld_q   <= vld_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      slot_adr   = '0;
      slot_data  = '0;
      slot_stale = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_adr[i]   = mem_q[i].adr;
         slot_data[i]  = mem_q[i].data;
         slot_stale[i] = mem_q[i].stale;
      end
   end

   assign rdy      = rdy_q;
   assign head_ptr = head_q;
   assign slot_vld = vld_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller merging the ALU path and the buffered long-latency path
// into the single register-file write port. Optional bypass lookup: WB_BYPASS_EN.
module regfile_wb_ctrl
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_vld,
   input  logic [AW-1:0]     alu_adr,
   input  logic [DW-1:0]     alu_data,
   input  logic              lu_vld,
   output logic              lu_rdy,
   input  logic [AW-1:0]     lu_adr,
   input  logic [DW-1:0]     lu_data,
   output logic              wr_en,
   output logic [AW-1:0]     wr_adr,
   output logic [DW-1:0]     wr_data,
   output logic [2**AW-1:0]  busy
`ifdef WB_BYPASS_EN
   ,
   input  logic [AW-1:0]     fwd_adr1,
   input  logic [AW-1:0]     fwd_adr2,
   output logic              fwd_hit1,
   output logic              fwd_hit2,
   output logic [DW-1:0]     fwd_data1,
   output logic [DW-1:0]     fwd_data2
`endif
);

   localparam int PW = $clog2(DEPTH);

   logic                         alu_commit;
   logic                         push;
   logic                         pop;
   logic                         head_vld;
   logic                         head_stale;
   logic [PW-1:0]                head_ptr;
   logic [DEPTH-1:0]             slot_vld;
   logic [DEPTH-1:0]             slot_stale;
   logic [DEPTH-1:0][AW-1:0]     slot_adr;
   logic [DEPTH-1:0][DW-1:0]     slot_data;

   logic              wr_en_q, wr_en_d;
   logic [AW-1:0]     wr_adr_q, wr_adr_d;
   logic [DW-1:0]     wr_data_q, wr_data_d;

   wb_pend_fifo #(.DEPTH(DEPTH)) u_pend (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_adr   (lu_adr),
      .push_data  (lu_data),
      .pop        (pop),
      .mark_en    (alu_commit),
      .mark_adr   (alu_adr),
      .rdy        (lu_rdy),
      .head_ptr   (head_ptr),
      .slot_vld   (slot_vld),
      .slot_stale (slot_stale),
      .slot_adr   (slot_adr),
      .slot_data  (slot_data)
   );

   // ALU owns the port; a stale head drains regardless since it writes nothing.
   always_comb begin
      alu_commit = alu_vld && (alu_adr != R0_ADR);
      push       = lu_vld && lu_rdy && (lu_adr != R0_ADR);
      head_vld   = slot_vld[head_ptr];
      head_stale = slot_stale[head_ptr];
      pop        = head_vld && (head_stale || !alu_commit);

      wr_en_d   = 1'b0;
      wr_adr_d  = wr_adr_q;
      wr_data_d = wr_data_q;
      if (alu_commit) begin
         wr_en_d   = 1'b1;
         wr_adr_d  = alu_adr;
         wr_data_d = alu_data;
      end else if (head_vld && !head_stale) begin
         wr_en_d   = 1'b1;
         wr_adr_d  = slot_adr[head_ptr];
         wr_data_d = slot_data[head_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_adr_q  <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_adr_q  <= wr_adr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_adr  = wr_adr_q;
   assign wr_data = wr_data_q;

   always_comb begin
      busy = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (slot_vld[s] && !slot_stale[s] && (slot_adr[s] == AW'(r))) begin
               busy[r] = 1'b1;
            end
         end
      end
   end

`ifdef WB_BYPASS_EN
   logic [1:0][AW-1:0] fwd_adr;
   logic [1:0]         fwd_hit;
   logic [1:0][DW-1:0] fwd_data;
   logic [PW-1:0]      idx;

   assign fwd_adr = {fwd_adr2, fwd_adr1};

   // Walk from head to tail so the youngest live match wins; the write stage beats all.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      idx      = '0;
      for (int p = 0; p < 2; p++) begin
         if (fwd_adr[p] != R0_ADR) begin
            for (int k = 0; k < DEPTH; k++) begin
               idx = head_ptr + PW'(k);
               if (slot_vld[idx] && !slot_stale[idx] && (slot_adr[idx] == fwd_adr[p])) begin
                  fwd_hit[p]  = 1'b1;
                  fwd_data[p] = slot_data[idx];
               end
            end
            if (wr_en_q && (wr_adr_q == fwd_adr[p])) begin
               fwd_hit[p]  = 1'b1;
               fwd_data[p] = wr_data_q;
            end
         end
      end
   end

   assign fwd_hit1  = fwd_hit[0];
   assign fwd_hit2  = fwd_hit[1];
   assign fwd_data1 = fwd_data[0];
   assign fwd_data2 = fwd_data[1];
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios followed by random
// traffic, compared against a queue-based model of the write-back rules.
module tb_regfile_wb_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_vld;
   logic [3:0]  alu_adr;
   logic [15:0] alu_data;
   logic        lu_vld;
   logic        lu_rdy;
   logic [3:0]  lu_adr;
   logic [15:0] lu_data;
   logic        wr_en;
   logic [3:0]  wr_adr;
   logic [15:0] wr_data;
   logic [15:0] busy;
`ifdef WB_BYPASS_EN
   logic [3:0]  fwd_adr1, fwd_adr2;
   logic        fwd_hit1, fwd_hit2;
   logic [15:0] fwd_data1, fwd_data2;
`endif

   typedef struct {
      logic [3:0]  adr;
      logic [15:0] data;
      bit          stale;
   } mdl_ent_t;

   mdl_ent_t    mdl_q[$];
   logic        exp_en;
   logic [3:0]  exp_adr;
   logic [15:0] exp_data;
   int          n_compared = 0;
   int          n_mismatched = 0;

   regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_vld   (alu_vld),
      .alu_adr   (alu_adr),
      .alu_data  (alu_data),
      .lu_vld    (lu_vld),
      .lu_rdy    (lu_rdy),
      .lu_adr    (lu_adr),
      .lu_data   (lu_data),
      .wr_en     (wr_en),
      .wr_adr    (wr_adr),
      .wr_data   (wr_data),
      .busy      (busy)
`ifdef WB_BYPASS_EN
      ,
      .fwd_adr1  (fwd_adr1),
      .fwd_adr2  (fwd_adr2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] mdl_busy();
      logic [15:0] b = '0;
      foreach (mdl_q[i]) if (!mdl_q[i].stale) b[mdl_q[i].adr] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   // Youngest source for an address: last issued write first, then newest live entry.
   task automatic mdl_lookup(input logic [3:0] a, output logic hit, output logic [15:0] d);
      hit = 1'b0;
      d   = '0;
      if (a != 4'd0) begin
         if (exp_en && exp_adr == a) begin
            hit = 1'b1;
            d   = exp_data;
         end else begin
            for (int i = mdl_q.size() - 1; i >= 0; i--) begin
               if (!hit && !mdl_q[i].stale && mdl_q[i].adr == a) begin
                  hit = 1'b1;
                  d   = mdl_q[i].data;
               end
            end
         end
      end
   endtask

   // One clock of traffic: drive, predict, clock, then compare.
   task automatic applyStimulus(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                                input logic lv, input logic [3:0] la, input logic [15:0] ld);
      bit rdy_now;
      bit commit;
      alu_vld  = av;
      alu_adr  = aa;
      alu_data = ad;
      lu_vld   = lv;
      lu_adr   = la;
      lu_data  = ld;

      rdy_now = (mdl_q.size() != DEPTH);
      checkOutput("lu_rdy", lu_rdy, rdy_now);

      commit = av && (aa != 4'd0);
      exp_en = 1'b0;
      if (mdl_q.size() > 0) begin
         if (mdl_q[0].stale) begin
            void'(mdl_q.pop_front());
         end else if (!commit) begin
            exp_en   = 1'b1;
            exp_adr  = mdl_q[0].adr;
            exp_data = mdl_q[0].data;
            void'(mdl_q.pop_front());
         end
      end
      if (commit) begin
         exp_en   = 1'b1;
         exp_adr  = aa;
         exp_data = ad;
         foreach (mdl_q[i]) if (mdl_q[i].adr == aa) mdl_q[i].stale = 1'b1;
      end
      if (lv && rdy_now && la != 4'd0) mdl_q.push_back('{adr: la, data: ld, stale: 1'b0});

      @(posedge clk);
      #1;
      checkOutput("wr_en", wr_en, exp_en);
      if (exp_en) begin
         checkOutput("wr_adr", wr_adr, exp_adr);
         checkOutput("wr_data", wr_data, exp_data);
      end
      checkOutput("busy", busy, mdl_busy());
`ifdef WB_BYPASS_EN
      begin
         logic        h;
         logic [15:0] d;
         fwd_adr1 = 4'($urandom_range(0, 15));
         fwd_adr2 = 4'($urandom_range(0, 15));
         #1;
         mdl_lookup(fwd_adr1, h, d);
         checkOutput("fwd_hit1", fwd_hit1, h);
         if (h) checkOutput("fwd_data1", fwd_data1, d);
         mdl_lookup(fwd_adr2, h, d);
         checkOutput("fwd_hit2", fwd_hit2, h);
         if (h) checkOutput("fwd_data2", fwd_data2, d);
      end
`endif
   endtask

   task automatic applyIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
   endtask

   // Reset with traffic still on the inputs; queued model state is discarded.
   task automatic doReset(input int n);
      rst      = 1'b1;
      alu_vld  = 1'b1;
      alu_adr  = 4'($urandom_range(1, 15));
      alu_data = 16'($urandom);
      lu_vld   = 1'b1;
      lu_adr   = 4'($urandom_range(1, 15));
      lu_data  = 16'($urandom);
      repeat (n) @(posedge clk);
      #1;
      rst     = 1'b0;
      alu_vld = 1'b0;
      lu_vld  = 1'b0;
      mdl_q.delete();
      exp_en  = 1'b0;
      checkOutput("rst_wr_en", wr_en, 1'b0);
      checkOutput("rst_wr_adr", wr_adr, 4'd0);
      checkOutput("rst_wr_data", wr_data, 16'd0);
      checkOutput("rst_busy", busy, 16'd0);
      checkOutput("rst_lu_rdy", lu_rdy, 1'b1);
   endtask

   initial begin
      rst      = 1'b1;
      alu_vld  = 1'b0;
      alu_adr  = '0;
      alu_data = '0;
      lu_vld   = 1'b0;
      lu_adr   = '0;
      lu_data  = '0;
      exp_en   = 1'b0;
      exp_adr  = '0;
      exp_data = '0;
`ifdef WB_BYPASS_EN
      fwd_adr1 = '0;
      fwd_adr2 = '0;
`endif
      doReset(2);

      applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0);
      checkOutput("alu_r3_adr", wr_adr, 4'd3);
      applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0);
      checkOutput("alu_r0_wr_en", wr_en, 1'b0);

      applyStimulus(1'b1, 4'd2, 16'h0202, 1'b1, 4'd5, 16'hAAAA);
      checkOutput("busy5_set", busy[5], 1'b1);
      applyStimulus(1'b1, 4'd4, 16'h0404, 1'b0, 4'd0, 16'd0);
      applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
      checkOutput("lu_r5_data", wr_data, 16'hAAAA);
      checkOutput("busy5_clr", busy[5], 1'b0);

      applyStimulus(1'b1, 4'd2, 16'h0222, 1'b1, 4'd7, 16'h1111);
      applyStimulus(1'b1, 4'd7, 16'h2222, 1'b0, 4'd0, 16'd0);
      checkOutput("stale_busy7", busy[7], 1'b0);
      applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
      checkOutput("stale_drain_wr_en", wr_en, 1'b0);
      applyIdle(2);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 4'd2 : 4'd4, 16'(i), 1'b1, 4'(8 + i), 16'(16'hB000 + i));
      end
      checkOutput("full_lu_rdy", lu_rdy, 1'b0);
      applyIdle(6);
      checkOutput("drain_lu_rdy", lu_rdy, 1'b1);

`ifdef WB_BYPASS_EN
      applyStimulus(1'b1, 4'd2, 16'h0002, 1'b1, 4'd6, 16'h0010);
      applyStimulus(1'b1, 4'd4, 16'h0004, 1'b1, 4'd6, 16'h0020);
      applyStimulus(1'b1, 4'd2, 16'h0003, 1'b0, 4'd0, 16'd0);
      fwd_adr1 = 4'd6;
      fwd_adr2 = 4'd0;
      #1;
      checkOutput("byp_hit1", fwd_hit1, 1'b1);
      checkOutput("byp_data1", fwd_data1, 16'h0020);
      checkOutput("byp_hit2_r0", fwd_hit2, 1'b0);
      applyIdle(3);
`endif

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'd1, 16'h0101, 1'b1, 4'(10 + i), 16'(16'hC000 + i));
      end
      doReset(2);
      applyIdle(4);

      for (int i = 0; i < 400; i++) begin
         if (i == 200) doReset(2);
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      end
      applyIdle(DEPTH + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
